// File: rtl/matrix_stack_ctrl.sv
// Multi-mode 4x4 matrix stack: push/pop/load/load-identity/write over a
// valid/ready command port, identity init at reset, combinational top peek.
module matrix_stack_ctrl #(
    parameter int                ELEM_W    = 32,
    parameter int                ROW_W     = 4*ELEM_W,
    parameter int                DEPTH     = 32,
    parameter int                NUM_MODES = 2,
    parameter int                MODE_W    = 1,
    parameter logic [ELEM_W-1:0] ONE_VAL   = 32'h3F800000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [MODE_W-1:0]        cmd_mode,
    input  logic [ROW_W-1:0]         data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic [ROW_W-1:0]         write_in_0,
    input  logic [ROW_W-1:0]         write_in_1,
    input  logic [ROW_W-1:0]         write_in_2,
    input  logic [ROW_W-1:0]         write_in_3,
    input  logic [MODE_W-1:0]        peek_mode,
    output logic [ROW_W-1:0]         peek_out_0,
    output logic [ROW_W-1:0]         peek_out_1,
    output logic [ROW_W-1:0]         peek_out_2,
    output logic [ROW_W-1:0]         peek_out_3,
    output logic [$clog2(DEPTH):0]   depth_out,
    output logic                     busy,
    output logic                     err_overflow,
    output logic                     err_underflow,
    output logic                     err_illegal
);
    localparam int SP_W = $clog2(DEPTH);
    localparam int MI_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam logic [SP_W-1:0]   SP_MAX = SP_W'(DEPTH-1);
    localparam logic [MI_W-1:0]   LAST_M = MI_W'(NUM_MODES-1);
    localparam logic [MODE_W:0]   NM_LIM = (MODE_W+1)'(NUM_MODES);

    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_LOAD_ID = 3'd4;
    localparam logic [2:0] OP_WRITE   = 3'd5;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE,
        S_PUSH0, S_PUSH1, S_PUSH2, S_PUSH3,
        S_LOAD0, S_LOAD1, S_LOAD2, S_LOAD3
    } state_t;

    state_t            state, state_nxt;
    logic [SP_W-1:0]   sp [NUM_MODES];
    logic [MI_W-1:0]   init_cnt;
    logic [MI_W-1:0]   cur_mi;
    logic [1:0]        row_k;
    logic [MI_W-1:0]   pm_i;
    logic [ROW_W-1:0]  mem [NUM_MODES][DEPTH][4];

    logic [MI_W-1:0]   cmd_mi;
    logic              legal;
    logic [SP_W-1:0]   cmd_sp, cur_sp;

    assign cmd_mi = cmd_mode[MI_W-1:0];
    assign legal  = ({1'b0, cmd_mode} < NM_LIM) && (cmd_op <= OP_WRITE);
    assign cmd_sp = sp[cmd_mi];
    assign cur_sp = sp[cur_mi];

    function automatic logic [ROW_W-1:0] id_row(input logic [1:0] r);
        logic [ROW_W-1:0] v;
        v = '0;
        case (r)
            2'd0:    v[ROW_W-1          -: ELEM_W] = ONE_VAL;
            2'd1:    v[ROW_W-1-ELEM_W   -: ELEM_W] = ONE_VAL;
            2'd2:    v[ROW_W-1-2*ELEM_W -: ELEM_W] = ONE_VAL;
            default: v[ROW_W-1-3*ELEM_W -: ELEM_W] = ONE_VAL;
        endcase
        return v;
    endfunction

    // Next-state and handshake outputs; multi-cycle ops walk one row per state.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        busy       = 1'b0;
        row_k      = 2'd0;
        case (state)
            S_INIT: begin
                busy = 1'b1;
                if (init_cnt == LAST_M) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && legal) begin
                    if (cmd_op == OP_PUSH && cmd_sp != SP_MAX) state_nxt = S_PUSH0;
                    else if (cmd_op == OP_LOAD)                state_nxt = S_LOAD0;
                end
            end
            S_PUSH0: begin busy = 1'b1; row_k = 2'd0; state_nxt = S_PUSH1; end
            S_PUSH1: begin busy = 1'b1; row_k = 2'd1; state_nxt = S_PUSH2; end
            S_PUSH2: begin busy = 1'b1; row_k = 2'd2; state_nxt = S_PUSH3; end
            S_PUSH3: begin busy = 1'b1; row_k = 2'd3; state_nxt = S_IDLE;  end
            S_LOAD0: begin busy = 1'b1; data_ready = 1'b1; row_k = 2'd0; if (data_valid) state_nxt = S_LOAD1; end
            S_LOAD1: begin busy = 1'b1; data_ready = 1'b1; row_k = 2'd1; if (data_valid) state_nxt = S_LOAD2; end
            S_LOAD2: begin busy = 1'b1; data_ready = 1'b1; row_k = 2'd2; if (data_valid) state_nxt = S_LOAD3; end
            S_LOAD3: begin busy = 1'b1; data_ready = 1'b1; row_k = 2'd3; if (data_valid) state_nxt = S_IDLE;  end
            default: state_nxt = S_INIT;
        endcase
    end

    // State, stack pointers, init counter and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_INIT;
            init_cnt      <= '0;
            cur_mi        <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_illegal   <= 1'b0;
            for (int m = 0; m < NUM_MODES; m++) sp[m] <= '0;
        end else begin
            state         <= state_nxt;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_illegal   <= 1'b0;
            case (state)
                S_INIT: init_cnt <= init_cnt + 1'b1;
                S_IDLE: if (cmd_valid) begin
                    cur_mi <= cmd_mi;
                    if (!legal) err_illegal <= 1'b1;
                    else if (cmd_op == OP_POP) begin
                        if (cmd_sp == '0) err_underflow <= 1'b1;
                        else              sp[cmd_mi] <= cmd_sp - 1'b1;
                    end else if (cmd_op == OP_PUSH && cmd_sp == SP_MAX)
                        err_overflow <= 1'b1;
                end
                S_PUSH3: sp[cur_mi] <= cur_sp + 1'b1;
                default: ;
            endcase
        end
    end

    // Matrix storage writes; slots outside slot 0 are left uninitialised.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state)
                S_INIT:
                    for (int r = 0; r < 4; r++) mem[init_cnt][SP_W'(0)][r] <= id_row(2'(r));
                S_IDLE: if (cmd_valid && legal) begin
                    if (cmd_op == OP_LOAD_ID) begin
                        for (int r = 0; r < 4; r++) mem[cmd_mi][cmd_sp][r] <= id_row(2'(r));
                    end else if (cmd_op == OP_WRITE) begin
                        mem[cmd_mi][cmd_sp][0] <= write_in_0;
                        mem[cmd_mi][cmd_sp][1] <= write_in_1;
                        mem[cmd_mi][cmd_sp][2] <= write_in_2;
                        mem[cmd_mi][cmd_sp][3] <= write_in_3;
                    end
                end
                S_PUSH0, S_PUSH1, S_PUSH2, S_PUSH3:
                    mem[cur_mi][cur_sp + 1'b1][row_k] <= mem[cur_mi][cur_sp][row_k];
                S_LOAD0, S_LOAD1, S_LOAD2, S_LOAD3:
                    if (data_valid) mem[cur_mi][cur_sp][row_k] <= data_in;
                default: ;
            endcase
        end
    end

    // Peek mode select; an out-of-range peek_mode falls back to mode 0.
    always_comb begin
        pm_i = '0;
        for (int m = 0; m < NUM_MODES; m++)
            if (peek_mode == MODE_W'(m)) pm_i = MI_W'(m);
    end

    assign peek_out_0 = mem[pm_i][sp[pm_i]][0];
    assign peek_out_1 = mem[pm_i][sp[pm_i]][1];
    assign peek_out_2 = mem[pm_i][sp[pm_i]][2];
    assign peek_out_3 = mem[pm_i][sp[pm_i]][3];
    assign depth_out  = {1'b0, sp[pm_i]} + (SP_W+1)'(1);
endmodule
